// File: rtl/glitch_sweep_ctrl_if.sv
// Control/status bundle between the glitch sequencer and its host/logger.
interface glitch_sweep_ctrl_if #(
    parameter int unsigned CNT_W = 28
);
    logic             arm;
    logic             mode;
    logic             trig;
    logic             g;
    logic             busy;
    logic             done;
    logic             led_init;
    logic             led_glitch;
    logic [CNT_W-1:0] cur_delay;
    logic [CNT_W-1:0] cur_width;

    modport master (
        output arm, mode, trig,
        input  g, busy, done, led_init, led_glitch, cur_delay, cur_width
    );

    modport slave (
        input  arm, mode, trig,
        output g, busy, done, led_init, led_glitch, cur_delay, cur_width
    );
endinterface

// File: rtl/glitch_sweep_ctrl.sv
// Voltage-glitch sequencer sweeping a (offset, width) grid, free-running or trigger-relative.
// Optional: define GLITCH_TRIG_HOLDOFF_EN to block trigger re-acceptance after each pulse.
module glitch_sweep_ctrl #(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned INIT_DELAY  = 24000000,
    parameter int unsigned DELAY_START = 70000,
    parameter int unsigned DELAY_STEP  = 2,
    parameter int unsigned DELAY_END   = 140000,
    parameter int unsigned WIDTH_START = 600,
    parameter int unsigned WIDTH_STEP  = 50,
    parameter int unsigned WIDTH_END   = 1000,
    parameter bit          G_ACTIVE    = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    glitch_sweep_ctrl_if.slave  bus
);

    localparam int unsigned EXT_W = CNT_W + 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WAIT_TRIG, S_DELAY, S_GLITCH, S_STEP, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cur_delay, cur_delay_nxt;
    logic [CNT_W-1:0] cur_width, cur_width_nxt;
    logic             mode_q, mode_nxt;
    logic             trig_s1, trig_s2, trig_s3;
    logic             trig_edge, trig_ok;
    logic             g_q, busy_q, done_q, led_init_q, led_glitch_q;
    logic [EXT_W-1:0] nd, nw;
    logic             last_point;

    // Next grid point computed one bit wider so an overflow is never mistaken for in-range.
    assign nd         = EXT_W'(cur_delay) + EXT_W'(DELAY_STEP);
    assign nw         = EXT_W'(cur_width) + EXT_W'(WIDTH_STEP);
    assign last_point = (nd > EXT_W'(DELAY_END)) && (nw > EXT_W'(WIDTH_END));
    assign trig_edge  = trig_s2 & ~trig_s3;

`ifdef GLITCH_TRIG_HOLDOFF_EN
    localparam int unsigned HOLDOFF = INIT_DELAY / 16;
    logic [CNT_W-1:0] holdoff;

    // Ignore target reboot noise for a while after every pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            holdoff <= '0;
        end else if (state_nxt == S_STEP) begin
            holdoff <= CNT_W'(HOLDOFF);
        end else if (holdoff != '0) begin
            holdoff <= holdoff - CNT_W'(1);
        end
    end
    assign trig_ok = trig_edge && (holdoff == '0);
`else
    assign trig_ok = trig_edge;
`endif

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cur_delay_nxt = cur_delay;
        cur_width_nxt = cur_width;
        mode_nxt      = mode_q;
        case (state)
            S_INIT: begin
                if (cnt == CNT_W'(INIT_DELAY - 1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (bus.arm) begin
                    mode_nxt  = bus.mode;
                    state_nxt = bus.mode ? S_WAIT_TRIG : S_DELAY;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_TRIG: begin
                if (!bus.arm) begin
                    state_nxt = S_IDLE;
                end else if (trig_ok) begin
                    state_nxt = S_DELAY;
                    cnt_nxt   = '0;
                end
            end
            S_DELAY: begin
                if (!bus.arm) begin
                    state_nxt = S_IDLE;
                end else if (cnt == cur_delay - CNT_W'(1)) begin
                    state_nxt = S_GLITCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            // Pulse always runs to full width; arm is not consulted here.
            S_GLITCH: begin
                if (cnt == cur_width - CNT_W'(1)) begin
                    state_nxt = S_STEP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_STEP: begin
                cnt_nxt = '0;
                if (nd <= EXT_W'(DELAY_END)) begin
                    cur_delay_nxt = CNT_W'(nd);
                end else if (nw <= EXT_W'(WIDTH_END)) begin
                    cur_delay_nxt = CNT_W'(DELAY_START);
                    cur_width_nxt = CNT_W'(nw);
                end
                if (last_point) begin
                    state_nxt = S_DONE;
                end else if (!bus.arm) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = mode_q ? S_WAIT_TRIG : S_DELAY;
                end
            end
            S_DONE: begin
                if (!bus.arm) begin
                    state_nxt     = S_IDLE;
                    cur_delay_nxt = CNT_W'(DELAY_START);
                    cur_width_nxt = CNT_W'(WIDTH_START);
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // State, sweep position, synchroniser and registered outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_INIT;
            cnt          <= '0;
            cur_delay    <= CNT_W'(DELAY_START);
            cur_width    <= CNT_W'(WIDTH_START);
            mode_q       <= 1'b0;
            trig_s1      <= 1'b0;
            trig_s2      <= 1'b0;
            trig_s3      <= 1'b0;
            g_q          <= ~G_ACTIVE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            led_init_q   <= 1'b1;
            led_glitch_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            cur_delay    <= cur_delay_nxt;
            cur_width    <= cur_width_nxt;
            mode_q       <= mode_nxt;
            trig_s1      <= bus.trig;
            trig_s2      <= trig_s1;
            trig_s3      <= trig_s2;
            g_q          <= (state_nxt == S_GLITCH) ? G_ACTIVE : ~G_ACTIVE;
            busy_q       <= !((state_nxt == S_IDLE) || (state_nxt == S_DONE));
            done_q       <= (state_nxt == S_DONE);
            led_init_q   <= (state_nxt == S_INIT);
            led_glitch_q <= (state_nxt == S_STEP);
        end
    end

    assign bus.g          = g_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.led_init   = led_init_q;
    assign bus.led_glitch = led_glitch_q;
    assign bus.cur_delay  = cur_delay;
    assign bus.cur_width  = cur_width;

endmodule
